// File: rtl/mips_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package mips_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int MAX_BURST_DEF    = 8;

  // Who currently owns the data memory port.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } own_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module sat_counter
  import mips_pkg::*;
#(
  parameter int MAX = STARVE_LIMIT_DEF,
  parameter int W   = cnt_bits(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM-stage cpu port
// (priority) and the debug/loader port (bounded starvation, bursts).
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read_en,
  input  logic              cpu_write_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  input  logic              dbg_write,
  input  logic              dbg_last,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int SW = cnt_bits(STARVE_LIMIT);
  localparam int BW = cnt_bits(MAX_BURST - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(MAX_BURST - 1);

  own_state_t        r_state;
  logic [BW-1:0]     r_beat;
  logic [SW-1:0]     w_starve;
  logic              w_cpu_req;
  logic              w_force;
  logic              w_cpu_grant;
  logic              w_dbg_grant;
  logic              w_starve_inc;
  logic              w_starve_clr;
  logic              w_burst_end;
  logic              w_dbg_rd;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_dbg_rdata;

  assign w_cpu_req   = cpu_read_en | cpu_write_en;
  assign w_force     = dbg_valid & (w_starve == STARVE_MAX);
  assign w_burst_end = dbg_last | (r_beat == LAST_BEAT);
  assign w_dbg_rd    = w_dbg_grant & ~dbg_write;

  // Grant decision: cpu first unless dbg has starved; dbg owns during a burst
  // but hands the port back in the very cycle it stops presenting beats.
  always_comb begin
    w_cpu_grant = 1'b0;
    w_dbg_grant = 1'b0;
    if (r_state == OWN_CPU) begin
      w_cpu_grant = w_cpu_req & ~w_force;
      w_dbg_grant = ~w_cpu_grant & dbg_valid;
    end else begin
      w_dbg_grant = dbg_valid;
      w_cpu_grant = ~dbg_valid & w_cpu_req;
    end
  end

  // Starvation only accumulates while dbg waits behind a cpu grant.
  assign w_starve_inc = (r_state == OWN_CPU) & w_cpu_grant & dbg_valid;
  assign w_starve_clr = ~w_starve_inc;

  sat_counter #(
    .MAX (STARVE_LIMIT),
    .W   (SW)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_cnt (w_starve)
  );

  // Memory port mux; a simultaneous cpu read+write is treated as a write.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    if (w_cpu_grant) begin
      mem_access_addr = cpu_addr;
      mem_write_data  = cpu_wdata;
      mem_write_en    = cpu_write_en;
      mem_read_en     = cpu_read_en & ~cpu_write_en;
    end else if (w_dbg_grant) begin
      mem_access_addr = dbg_addr;
      mem_write_data  = dbg_wdata;
      mem_write_en    = dbg_write;
      mem_read_en     = ~dbg_write;
    end
  end

  assign cpu_stall  = w_cpu_req & ~w_cpu_grant;
  assign cpu_rdata  = mem_read_data;
  assign dbg_ready  = w_dbg_grant;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;

  // Ownership FSM with inline burst beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OWN_CPU;
      r_beat  <= '0;
    end else if (r_state == OWN_CPU) begin
      if (w_dbg_grant && !dbg_last) begin
        r_state <= OWN_DBG;
        r_beat  <= BW'(1);
      end
    end else begin
      if (dbg_valid && !w_burst_end) begin
        r_beat <= r_beat + 1'b1;
      end else begin
        r_state <= OWN_CPU;
        r_beat  <= '0;
      end
    end
  end

  // Registered dbg read response; data holds between accepted reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_dbg_rvalid <= w_dbg_rd;
      if (w_dbg_rd) begin
        r_dbg_rdata <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;
  import mips_pkg::*;

  localparam int SL = 4;
  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read_en, cpu_write_en;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_valid, dbg_write, dbg_last;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ready, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_write(dbg_write), .dbg_last(dbg_last),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_read_data(mem_read_data)
  );

  // Environment data memory: combinational read, write at clock edge.
  logic [31:0] tb_mem [0:255];
  assign mem_read_data = tb_mem[mem_access_addr[7:0]];
  always @(posedge clk) if (mem_write_en) tb_mem[mem_access_addr[7:0]] <= mem_write_data;

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  int          m_own, m_starve, m_beat;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  // Samples taken mid-cycle for directed checks.
  logic        s_ready, s_stall, s_we, s_re, s_rvalid;
  logic [31:0] s_rdata, s_cpu_rdata, s_addr;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_cycle();
    bit          req, cg, dg, frc, ewe, ere;
    logic [31:0] ea, ewd;
    @(negedge clk);
    req = cpu_read_en || cpu_write_en;
    if (m_own == 0) begin
      frc = dbg_valid && (m_starve == SL);
      cg  = req && !frc;
      dg  = !cg && dbg_valid;
    end else begin
      dg = dbg_valid;
      cg = !dbg_valid && req;
    end
    ea = 0; ewd = 0; ewe = 0; ere = 0;
    if (cg) begin
      ea = cpu_addr; ewd = cpu_wdata; ewe = cpu_write_en; ere = !cpu_write_en;
    end else if (dg) begin
      ea = dbg_addr; ewd = dbg_wdata; ewe = dbg_write; ere = !dbg_write;
    end
    s_ready = dbg_ready; s_stall = cpu_stall; s_we = mem_write_en; s_re = mem_read_en;
    s_rvalid = dbg_rvalid; s_rdata = dbg_rdata; s_cpu_rdata = cpu_rdata; s_addr = mem_access_addr;
    chk("dbg_ready", dbg_ready, dg);
    chk("cpu_stall", cpu_stall, req && !cg);
    chk("mem_we", mem_write_en, ewe);
    chk("mem_re", mem_read_en, ere);
    chk("mem_addr", mem_access_addr, ea);
    chk("mem_wdata", mem_write_data, ewd);
    chk("dbg_rvalid", dbg_rvalid, m_rvalid);
    chk("dbg_rdata", dbg_rdata, m_rdata);
    chk("state", dut.r_state, m_own);
    if (cg && ere) chk("cpu_rdata", cpu_rdata, ref_mem[ea[7:0]]);
    @(posedge clk);
    if (cg && cpu_write_en) ref_mem[cpu_addr[7:0]] = cpu_wdata;
    if (dg && dbg_write) ref_mem[dbg_addr[7:0]] = dbg_wdata;
    if (reset) begin
      m_own = 0; m_starve = 0; m_beat = 0; m_rvalid = 0; m_rdata = 0;
    end else begin
      m_rvalid = dg && !dbg_write;
      if (m_rvalid) m_rdata = ref_mem[dbg_addr[7:0]];
      if (m_own == 0 && cg && dbg_valid) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else m_starve = 0;
      if (m_own == 0) begin
        if (dg && !dbg_last) begin m_own = 1; m_beat = 1; end
      end else if (dbg_valid && !dbg_last && m_beat < MB - 1) begin
        m_beat++;
      end else begin
        m_own = 0; m_beat = 0;
      end
    end
    #1;
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic dv, input logic dw, input logic dl,
                     input logic [31:0] da, input logic [31:0] dwd);
    cpu_read_en = rd; cpu_write_en = wr; cpu_addr = a; cpu_wdata = wd;
    dbg_valid = dv; dbg_write = dw; dbg_last = dl; dbg_addr = da; dbg_wdata = dwd;
    run_cycle();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k, cur_run, gap, r0, r1;
    int runs[$];
    bit hold_cpu, hold_dbg;
    for (int i = 0; i < 256; i++) begin tb_mem[i] = 0; ref_mem[i] = 0; end
    m_own = 0; m_starve = 0; m_beat = 0; m_rvalid = 0; m_rdata = 0;
    reset = 1'b1;
    cpu_read_en = 0; cpu_write_en = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_valid = 0; dbg_write = 0; dbg_last = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    idle();
    chk("rst_rvalid", s_rvalid, 0); chk("rst_rdata", s_rdata, 0);
    chk("rst_we", s_we, 0); chk("rst_re", s_re, 0);
    chk("rst_stall", s_stall, 0); chk("rst_ready", s_ready, 0);
    chk("rst_addr", s_addr, 0);

    // cpu write then read back
    cyc(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("t1_we", s_we, 1); chk("t1_stall", s_stall, 0);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("t1_rdata", s_cpu_rdata, 32'hDEADBEEF);

    // dbg single read
    cyc(0, 0, 0, 0, 1, 0, 1, 32'h10, 0);
    chk("t2_ready", s_ready, 1);
    idle();
    chk("t2_rvalid", s_rvalid, 1); chk("t2_rdata", s_rdata, 32'hDEADBEEF);
    chk("t2_state", dut.r_state, 0);

    // starvation bound
    for (int c = 1; c <= 6; c++) begin
      cyc(1, 0, 32'h20, 0, 1, 1, 1, 32'h30, 32'h12345678);
      if (c <= 4) chk("t3_wait", s_ready, 0);
      else if (c == 5) begin chk("t3_force_ready", s_ready, 1); chk("t3_force_stall", s_stall, 1); end
      else begin chk("t3_back_ready", s_ready, 0); chk("t3_back_stall", s_stall, 0); end
    end
    idle();

    // 10-beat write burst against a busy cpu
    k = 0; cur_run = 0; gap = 0;
    for (int c = 0; c < 200 && k < 10; c++) begin
      cyc(1, 0, 32'h24, 0, 1, 1, (k == 9), 32'h40 + k, 32'hA000 + k);
      if (s_ready) begin
        chk("t4_stall_own", s_stall, 1);
        k++; cur_run++;
      end else begin
        if (cur_run > 0) runs.push_back(cur_run);
        cur_run = 0;
        if (!s_stall && runs.size() >= 1) gap++;
      end
    end
    if (cur_run > 0) runs.push_back(cur_run);
    r0 = (runs.size() > 0) ? runs[0] : -1;
    r1 = (runs.size() > 1) ? runs[1] : -1;
    chk("t4_done", k, 10); chk("t4_run0", r0, 8); chk("t4_run1", r1, 2);
    chk("t4_gap", gap >= 1, 1);
    idle();

    // dbg drops valid mid-burst
    cyc(0, 0, 0, 0, 1, 1, 0, 32'h50, 32'h1);
    cyc(0, 0, 0, 0, 1, 1, 0, 32'h51, 32'h2);
    cyc(0, 0, 0, 0, 1, 1, 0, 32'h52, 32'h3);
    chk("t5_own", dut.r_state, 1);
    cyc(0, 1, 32'h54, 32'h77, 0, 0, 0, 0, 0);
    chk("t5_stall", s_stall, 0); chk("t5_we", s_we, 1);
    chk("t5_state", dut.r_state, 0);

    // reset mid-burst after a read accept
    cyc(0, 0, 0, 0, 1, 0, 0, 32'h10, 0);
    chk("t6_own", dut.r_state, 1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("t6_state", dut.r_state, 0); chk("t6_beat", dut.r_beat, 0);
    chk("t6_starve", dut.w_starve, 0);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("t6_rvalid", s_rvalid, 0); chk("t6_stall", s_stall, 0);
    chk("t6_cpu_rdata", s_cpu_rdata, 32'hDEADBEEF);

    // randomized traffic
    hold_cpu = 0; hold_dbg = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hold_cpu) begin
        cpu_read_en  = ($urandom_range(0, 2) == 0);
        cpu_write_en = ($urandom_range(0, 3) == 0);
        cpu_addr     = $urandom_range(0, 15);
        cpu_wdata    = $urandom;
      end
      if (!hold_dbg) begin
        dbg_valid = ($urandom_range(0, 2) != 0);
        dbg_write = $urandom_range(0, 1);
        dbg_last  = ($urandom_range(0, 4) == 0);
        dbg_addr  = $urandom_range(0, 15);
        dbg_wdata = $urandom;
      end
      reset = ($urandom_range(0, 99) == 0);
      run_cycle();
      hold_cpu = s_stall;
      hold_dbg = dbg_valid && !s_ready;
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (cpu port) and an external debug/loader port (dbg port).
The cpu port has priority. A starvation counter bounds how long dbg can wait, and dbg may hold the memory for bursts.
When the cpu loses arbitration, the block raises cpu_stall, which the pipeline uses to freeze PC, IF/ID, ID/EX and EX/MEM.
The block sits between the EX/MEM register outputs and the data_memory instance.

Parameters:
ADDR_W, 32, address width of both ports and memory
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive cycles a pending dbg request may lose before it is forced a grant
MAX_BURST, 8, maximum beats per dbg ownership period

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_read_en  in  1  MEM-stage load request
cpu_write_en  in  1  MEM-stage store request
cpu_addr  in  ADDR_W  MEM-stage address
cpu_wdata  in  DATA_W  MEM-stage store data
cpu_rdata  out  DATA_W  load data to the MEM/WB register
cpu_stall  out  1  pipeline freeze request
dbg_valid  in  1  dbg beat valid
dbg_write  in  1  1 = write beat, 0 = read beat
dbg_last  in  1  final beat of the burst
dbg_addr  in  ADDR_W  dbg address
dbg_wdata  in  DATA_W  dbg write data
dbg_ready  out  1  dbg beat accepted this cycle
dbg_rvalid  out  1  registered read-data valid
dbg_rdata  out  DATA_W  registered read data
mem_access_addr  out  ADDR_W  to data_memory
mem_write_data  out  DATA_W  to data_memory
mem_write_en  out  1  to data_memory
mem_read_en  out  1  to data_memory
mem_read_data  in  DATA_W  from data_memory; combinational read

Behaviour:
- Request and beat definitions:
  - cpu_req = cpu_read_en | cpu_write_en.
  - A dbg beat is accepted when dbg_valid & dbg_ready.
- States:
  - OWN_CPU is the reset state.
  - OWN_DBG.
- Counters:
  - starve_cnt: 0..STARVE_LIMIT, saturating.
  - beat_cnt: 0..MAX_BURST-1.
- OWN_CPU:
  - force = dbg_valid & (starve_cnt == STARVE_LIMIT).
  - If cpu_req and not force: cpu is granted. If dbg_valid, starve_cnt increments (saturating); otherwise starve_cnt clears.
  - Else if dbg_valid: dbg is granted (dbg_ready=1) and starve_cnt clears.
    - If the granted beat has dbg_last=0, go to OWN_DBG with beat_cnt=1.
    - Otherwise stay in OWN_CPU.
- OWN_DBG:
  - dbg_ready = dbg_valid; the cpu is never granted.
  - Accepted beat with dbg_last=1, or with beat_cnt==MAX_BURST-1: go to OWN_CPU and clear beat_cnt.
  - Any other accepted beat: beat_cnt increments.
  - dbg_valid=0 releases ownership immediately: same cycle, so the cpu can be granted in this cycle, then go to OWN_CPU.
- Grant behaviour:
  - cpu_stall = cpu_req & ~cpu_grant (combinational).
  - The granted requester drives mem_* combinationally.
  - With no grant, mem_write_en and mem_read_en are 0 and addr/wdata are 0.
  - A write commits at the clk edge ending the granted cycle.
- Read data:
  - cpu_rdata = mem_read_data passthrough, valid in the cpu grant cycle.
  - dbg_rdata/dbg_rvalid are registered: dbg_rvalid=1 exactly one cycle after an accepted read beat.
  - dbg_rdata holds its last value otherwise.
- A stalled cpu must hold its request stable; the arbiter does not latch cpu requests.
- Reset (synchronous, any cycle, including mid-burst):
  - State goes to OWN_CPU, both counters to 0, dbg_rvalid=0, dbg_rdata=0.
  - A pending read response is dropped.
  - Combinational outputs follow from the reset state.
- Simultaneous events:
  - cpu_read_en and cpu_write_en both high: treated as a write.
  - dbg_last together with beat_cnt==MAX_BURST-1: single exit, no double count.

Decomposition:
- Shared package mips_pkg holds:
  - the owner-state enum (OWN_CPU, OWN_DBG);
  - DATA_W/ADDR_W defaults;
  - the STARVE_LIMIT and MAX_BURST defaults.
- One natural sub-module: sat_counter, a saturating up-counter with clear, used for starve_cnt.
- beat_cnt and the FSM stay inline.

Test Plan:
- Reset then idle: all outputs 0 and state OWN_CPU. A cpu write to 0x10 of 0xDEADBEEF gives mem_write_en=1 and cpu_stall=0 in the same cycle; a later cpu read of 0x10 returns 0xDEADBEEF on cpu_rdata.
- Idle cpu, dbg single read of 0x10 with dbg_last=1: dbg_ready=1 in the same cycle, dbg_rvalid=1 with dbg_rdata=0xDEADBEEF one cycle later, state remains OWN_CPU.
- cpu_req held high continuously and dbg_valid high: dbg_ready=0 for 4 cycles (starve_cnt 1..4). Cycle 5 gives dbg_ready=1 and cpu_stall=1. Cycle 6 returns the grant to the cpu.
- dbg 10-beat write burst (dbg_last on beat 10) while the cpu requests: the first ownership ends after 8 beats, the cpu gets at least one grant, and the remaining 2 beats complete later. cpu_stall=1 throughout the dbg ownership.
- dbg burst with dbg_valid dropped after beat 3: the cpu is granted in the drop cycle (cpu_stall=0) and the state returns to OWN_CPU.
- reset asserted in OWN_DBG one cycle after a dbg read accept: next cycle shows dbg_rvalid=0, state OWN_CPU, counters 0, and a cpu request is granted.
